serv_bufreg2_ctrl: RTL and testbench
====================================

# serv_bufreg2_ctrl

Sequencer for the SERV buffer register (bufreg2) and its Wishbone data port. It accepts one load, store or shift command at a time and walks bufreg2 through its init, wait, count-down and stream-out phases by driving its control strobes. For loads and stores it also runs the data-bus handshake. It sits between the decoder/state logic and bufreg2, and replaces ad-hoc phase decoding in the core state block.

## Interface
- BITS_PER_CYCLE, 1: datapath width W per cycle. Legal values: 1, 2, 4, 8, 16, 32. One phase lasts 32/W cycles.
- i_clk  in  1  clock; all state changes on its rising edge
- i_rst  in  1  reset, synchronous, active-high
- i_start  in  1  command strobe; sampled only in IDLE
- i_op  in  2  command: 0 load, 1 store, 2 shift, 3 reserved (treated as no-op)
- i_right_shift  in  1  shift direction; passed through as o_right_shift_op
- i_size  in  2  access size: 0 byte, 1 half, 2 word
- i_addr_lsb  in  2  address bits [1:0]; latched at start
- i_sh_done  in  1  o_sh_done from bufreg2
- i_wb_ack  in  1  data-bus acknowledge
- o_en  out  1  bufreg2 i_en
- o_init  out  1  bufreg2 i_init
- o_cnt_done  out  1  last cycle of the current phase
- o_lsb  out  2  latched i_addr_lsb, held until the next start
- o_byte_valid  out  1  bufreg2 i_byte_valid
- o_shift_op  out  1  bufreg2 i_shift_op
- o_right_shift_op  out  1  bufreg2 i_right_shift_op
- o_load  out  1  bufreg2 i_load
- o_wb_cyc  out  1  bus request
- o_wb_we  out  1  write enable
- o_wb_sel  out  4  byte lanes
- o_busy  out  1  state is not IDLE
- o_done  out  1  one-cycle completion pulse
- o_misalign  out  1  one-cycle pulse, coincident with o_done, on a rejected access

## Operation
- States: IDLE, INIT, WAIT_ACK, SHIFT, EXEC.
- Bit counter `cnt` is 5 bits wide. It steps by W each cycle in INIT and EXEC, and is cleared on entry to either state.
- o_cnt_done = (cnt == 32-W) while in INIT or EXEC. It is 0 in all other states.
- IDLE, on i_start:
  - latch i_op, i_size, i_addr_lsb and i_right_shift;
  - if the access is misaligned (load/store with half and lsb==3, or word and lsb!=0): pulse o_done and o_misalign on the next cycle and stay in IDLE;
  - if i_op is 3: pulse o_done and stay in IDLE;
  - otherwise go to INIT.
- INIT:
  - o_init=1.
  - Load/store: o_en=1.
  - Store: o_byte_valid = (cnt[4:3] < 2^size). This clamps word to all 4 bytes.
  - Load: o_byte_valid=0.
  - Shift: o_shift_op=1 and o_en=1.
  - On o_cnt_done: load/store go to WAIT_ACK; shift goes to SHIFT.
- WAIT_ACK:
  - o_wb_cyc=1; o_wb_we=1 for store.
  - o_wb_sel: byte = 0001<<lsb, half = 0011<<lsb, word = 1111.
  - On i_wb_ack: store goes to IDLE with o_done. Load pulses o_load in the ack cycle and goes to EXEC.
  - i_wb_ack is ignored outside WAIT_ACK.
- SHIFT:
  - o_shift_op=1, o_init=0, o_en=0.
  - Leave when i_sh_done=1 and go to EXEC.
- EXEC:
  - o_en=1 and o_byte_valid=1 for loads.
  - Shift: o_shift_op=1.
  - On o_cnt_done: go to IDLE and pulse o_done.
- Reserved i_op and misalignment never touch the bus.

## Timing
- Reset: state IDLE, cnt 0, all outputs 0, including o_lsb.
- Reset wins over every other event, including mid-bus-cycle. o_wb_cyc drops the cycle after i_rst is sampled high.
- The command is accepted on the edge where IDLE and i_start are both high. INIT outputs appear in the next cycle.
- Load latency (no ack stall): 32/W INIT + 1 WAIT_ACK + 32/W EXEC. o_done comes 1 cycle after the last EXEC cycle.
- Store latency: 32/W + 1 cycles to o_done, plus any ack wait cycles.
- Shift: INIT 32/W cycles. SHIFT lasts until i_sh_done; i_sh_done in the first SHIFT cycle gives exactly one SHIFT cycle. Then EXEC 32/W cycles.
- o_wb_cyc, o_wb_we and o_wb_sel are stable for the whole of WAIT_ACK.
- o_load is high only in the ack cycle.
- o_done is asserted for exactly one cycle, in IDLE. A new i_start in that same cycle is accepted.
- i_start while busy is ignored and is not queued.

## Test plan
- Reset with i_start=1 and i_rst=1 for 2 cycles -> all outputs 0, stays IDLE.
- W=1 word load at lsb=0, ack after 3 wait cycles -> o_init high 32 cycles; o_wb_sel=1111; o_load coincident with ack; o_en high 32 EXEC cycles; o_done at cycle 32+4+32+1.
- W=4 byte store at lsb=2 -> o_byte_valid high only for INIT cycles 0-1; o_wb_sel=0100; o_wb_we=1; o_done 1 cycle after ack.
- Half store at lsb=3 -> o_misalign and o_done pulse 1 cycle after start; o_wb_cyc never asserts.
- W=2 right shift, i_sh_done driven high 5 cycles after SHIFT entry -> o_right_shift_op=1; 16 INIT, 6 SHIFT and 16 EXEC cycles; o_done once.
- i_rst pulsed mid-WAIT_ACK during a load -> o_wb_cyc low next cycle; no o_load or o_done; a subsequent i_start is accepted normally.

Source files
------------

// File: rtl/serv_bufreg2_ctrl.sv
// Sequencer for the SERV bufreg2: steps it through init, bus-wait, shift-wait and
// execute phases, and runs the Wishbone data-port handshake for loads and stores.
module serv_bufreg2_ctrl #(
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_start,
  input  logic [1:0] i_op,
  input  logic       i_right_shift,
  input  logic [1:0] i_size,
  input  logic [1:0] i_addr_lsb,
  input  logic       i_sh_done,
  input  logic       i_wb_ack,
  output logic       o_en,
  output logic       o_init,
  output logic       o_cnt_done,
  output logic [1:0] o_lsb,
  output logic       o_byte_valid,
  output logic       o_shift_op,
  output logic       o_right_shift_op,
  output logic       o_load,
  output logic       o_wb_cyc,
  output logic       o_wb_we,
  output logic [3:0] o_wb_sel,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_misalign
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_WAIT_ACK,
    S_SHIFT,
    S_EXEC
  } state_t;

  localparam logic [1:0] OP_LOAD  = 2'd0;
  localparam logic [1:0] OP_STORE = 2'd1;
  localparam logic [1:0] OP_SHIFT = 2'd2;
  localparam logic [1:0] OP_RSVD  = 2'd3;

  // With 32 bits per cycle the step wraps to zero and every cycle is the last one.
  localparam logic [4:0] CNT_STEP = 5'(BITS_PER_CYCLE);
  localparam logic [4:0] CNT_LAST = 5'(32 - BITS_PER_CYCLE);

  state_t     state_q, state_d;
  logic [4:0] cnt_q, cnt_d;
  logic [1:0] op_q, op_d;
  logic [1:0] size_q, size_d;
  logic [1:0] lsb_q, lsb_d;
  logic       rshift_q, rshift_d;
  logic       done_q, done_d;
  logic       misalign_q, misalign_d;

  logic counting;
  logic cnt_done;
  logic is_load;
  logic is_store;
  logic is_shift;
  logic start_misaligned;
  logic store_byte_valid;

  assign counting = (state_q == S_INIT) || (state_q == S_EXEC);
  assign cnt_done = counting && (cnt_q == CNT_LAST);
  assign is_load  = (op_q == OP_LOAD);
  assign is_store = (op_q == OP_STORE);
  assign is_shift = (op_q == OP_SHIFT);

  assign start_misaligned = ((i_op == OP_LOAD) || (i_op == OP_STORE)) &&
                            (((i_size == 2'd1) && (i_addr_lsb == 2'd3)) ||
                             ((i_size == 2'd2) && (i_addr_lsb != 2'd0)));

  // Store lanes fill in 8-bit groups; 2^size groups are valid, a word covers all four.
  assign store_byte_valid = ({2'b00, cnt_q[4:3]} < (4'd1 << size_q));

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    size_d       = size_q;
    lsb_d        = lsb_q;
    rshift_d     = rshift_q;
    done_d       = 1'b0;
    misalign_d   = 1'b0;
    o_en         = 1'b0;
    o_init       = 1'b0;
    o_byte_valid = 1'b0;
    o_shift_op   = 1'b0;
    o_load       = 1'b0;
    o_wb_cyc     = 1'b0;
    o_wb_we      = 1'b0;
    o_wb_sel     = 4'b0000;

    unique case (state_q)
      S_IDLE: begin
        if (i_start) begin
          op_d     = i_op;
          size_d   = i_size;
          lsb_d    = i_addr_lsb;
          rshift_d = i_right_shift;
          if (start_misaligned) begin
            done_d     = 1'b1;
            misalign_d = 1'b1;
          end else if (i_op == OP_RSVD) begin
            done_d = 1'b1;
          end else begin
            state_d = S_INIT;
          end
        end
      end
      S_INIT: begin
        o_init       = 1'b1;
        o_en         = 1'b1;
        o_byte_valid = is_store && store_byte_valid;
        o_shift_op   = is_shift;
        if (cnt_done) begin
          state_d = is_shift ? S_SHIFT : S_WAIT_ACK;
        end
      end
      S_WAIT_ACK: begin
        o_wb_cyc = 1'b1;
        o_wb_we  = is_store;
        case (size_q)
          2'd0:    o_wb_sel = 4'b0001 << lsb_q;
          2'd1:    o_wb_sel = 4'b0011 << lsb_q;
          default: o_wb_sel = 4'b1111;
        endcase
        if (i_wb_ack) begin
          if (is_store) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            o_load  = 1'b1;
            state_d = S_EXEC;
          end
        end
      end
      S_SHIFT: begin
        o_shift_op = 1'b1;
        if (i_sh_done) begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        o_en         = 1'b1;
        o_byte_valid = is_load;
        o_shift_op   = is_shift;
        if (cnt_done) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // The counter restarts from zero whenever a counting phase is entered.
  always_comb begin
    cnt_d = 5'd0;
    if (counting && (state_d == state_q)) begin
      cnt_d = cnt_q + CNT_STEP;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= 5'd0;
      op_q       <= 2'd0;
      size_q     <= 2'd0;
      lsb_q      <= 2'd0;
      rshift_q   <= 1'b0;
      done_q     <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_q       <= op_d;
      size_q     <= size_d;
      lsb_q      <= lsb_d;
      rshift_q   <= rshift_d;
      done_q     <= done_d;
      misalign_q <= misalign_d;
    end
  end

  assign o_cnt_done       = cnt_done;
  assign o_lsb            = lsb_q;
  assign o_right_shift_op = rshift_q;
  assign o_busy           = (state_q != S_IDLE);
  assign o_done           = done_q;
  assign o_misalign       = misalign_q;

endmodule

// File: tb/tb_serv_bufreg2_ctrl.sv
// Scoreboard bench for serv_bufreg2_ctrl: three instances (W=1,2,4) share stimulus,
// one is observed at a time and per-command phase counts are checked on o_done.
`timescale 1ns/1ps
module tb_serv_bufreg2_ctrl;

  typedef struct packed {
    logic       en;
    logic       init;
    logic       cnt_done;
    logic [1:0] lsb;
    logic       byte_valid;
    logic       shift_op;
    logic       rso;
    logic       load;
    logic       wb_cyc;
    logic       wb_we;
    logic [3:0] wb_sel;
    logic       busy;
    logic       done;
    logic       misalign;
  } outs_t;

  typedef struct {
    int latency;
    int misalign;
    int lsb;
    int initCnt;
    int enCnt;
    int cycCnt;
    int loadCnt;
    int bvCnt;
    int shOpCnt;
    int shStateCnt;
    int cntDoneCnt;
    int sel;
    int we;
    int rsoCnt;
  } exp_t;

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b0;
  logic       i_start = 1'b0;
  logic [1:0] i_op = 2'd0;
  logic       i_right_shift = 1'b0;
  logic [1:0] i_size = 2'd0;
  logic [1:0] i_addr_lsb = 2'd0;
  logic       i_sh_done = 1'b0;
  logic       i_wb_ack = 1'b0;

  outs_t outsArr [3];
  outs_t obs;
  int    cur = 0;

  always #5 i_clk = ~i_clk;

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    localparam int WI = (gi == 0) ? 1 : ((gi == 1) ? 2 : 4);
    logic       en, init, cnt_done, byte_valid, shift_op, rso, load;
    logic       wb_cyc, wb_we, busy, done, misalign;
    logic [1:0] lsb;
    logic [3:0] wb_sel;

    serv_bufreg2_ctrl #(.BITS_PER_CYCLE(WI)) dut (
      .i_clk           (i_clk),
      .i_rst           (i_rst),
      .i_start         (i_start),
      .i_op            (i_op),
      .i_right_shift   (i_right_shift),
      .i_size          (i_size),
      .i_addr_lsb      (i_addr_lsb),
      .i_sh_done       (i_sh_done),
      .i_wb_ack        (i_wb_ack),
      .o_en            (en),
      .o_init          (init),
      .o_cnt_done      (cnt_done),
      .o_lsb           (lsb),
      .o_byte_valid    (byte_valid),
      .o_shift_op      (shift_op),
      .o_right_shift_op(rso),
      .o_load          (load),
      .o_wb_cyc        (wb_cyc),
      .o_wb_we         (wb_we),
      .o_wb_sel        (wb_sel),
      .o_busy          (busy),
      .o_done          (done),
      .o_misalign      (misalign)
    );

    assign outsArr[gi] = {en, init, cnt_done, lsb, byte_valid, shift_op, rso, load,
                          wb_cyc, wb_we, wb_sel, busy, done, misalign};
  end

  always_comb obs = outsArr[cur];

  int checks = 0;
  int errors = 0;
  exp_t expQ[$];

  int txCycle = 0;
  int doneEvents = 0;
  int mInit, mEn, mCyc, mLoad, mLoadOffAck, mBv, mShOp, mShState, mCntDone, mRso, mBusUnstable;
  logic [3:0] mSel;
  logic       mWe;

  function automatic int widthOf(input int idx);
    return (idx == 0) ? 1 : ((idx == 1) ? 2 : 4);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
    end
  endtask

  task automatic clearMonitor();
    txCycle = -1;
    mInit = 0; mEn = 0; mCyc = 0; mLoad = 0; mLoadOffAck = 0; mBv = 0;
    mShOp = 0; mShState = 0; mCntDone = 0; mRso = 0; mBusUnstable = 0;
    mSel = 4'd0; mWe = 1'b0;
  endtask

  // Per-cycle observation of the selected instance; o_done retires one expectation.
  always @(negedge i_clk) begin
    exp_t e;
    txCycle++;
    if (obs.init) mInit++;
    if (obs.en) mEn++;
    if (obs.byte_valid) mBv++;
    if (obs.shift_op) mShOp++;
    if (obs.shift_op && !obs.init && !obs.en) mShState++;
    if (obs.shift_op && obs.rso) mRso++;
    if (obs.cnt_done) mCntDone++;
    if (obs.wb_cyc) begin
      if (mCyc == 0) begin
        mSel = obs.wb_sel;
        mWe  = obs.wb_we;
      end else if (obs.wb_sel != mSel || obs.wb_we != mWe) begin
        mBusUnstable++;
      end
      mCyc++;
    end
    if (obs.load) begin
      mLoad++;
      if (!(i_wb_ack && obs.wb_cyc)) mLoadOffAck++;
    end
    if (obs.done) begin
      doneEvents++;
      if (expQ.size() == 0) begin
        checkOutput("unexpectedDone", 1, 0);
      end else begin
        e = expQ.pop_front();
        checkOutput("latency", txCycle, e.latency);
        checkOutput("doneIdle", obs.busy, 0);
        checkOutput("misalign", obs.misalign, e.misalign);
        checkOutput("lsb", obs.lsb, e.lsb);
        checkOutput("initCycles", mInit, e.initCnt);
        if (e.enCnt >= 0) checkOutput("enCycles", mEn, e.enCnt);
        checkOutput("cycCycles", mCyc, e.cycCnt);
        checkOutput("loadPulses", mLoad, e.loadCnt);
        checkOutput("loadOffAck", mLoadOffAck, 0);
        checkOutput("byteValidCycles", mBv, e.bvCnt);
        checkOutput("shiftOpCycles", mShOp, e.shOpCnt);
        checkOutput("shiftStateCycles", mShState, e.shStateCnt);
        checkOutput("cntDonePulses", mCntDone, e.cntDoneCnt);
        checkOutput("rsoCycles", mRso, e.rsoCnt);
        if (e.cycCnt > 0) begin
          checkOutput("wbSel", mSel, e.sel);
          checkOutput("wbWe", mWe, e.we);
          checkOutput("busStable", mBusUnstable, 0);
        end
      end
    end
  end

  task automatic resetDuts();
    i_rst = 1'b1;
    i_start = 1'b1;
    i_op = 2'd0;
    i_wb_ack = 1'b0;
    i_sh_done = 1'b0;
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("resetOuts%0d", i), 32'(outsArr[i]), 0);
    end
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    i_start = 1'b0;
    expQ.delete();
  endtask

  task automatic waitDone(input int doneBefore);
    bit got = 0;
    for (int k = 0; k < 400 && !got; k++) begin
      @(posedge i_clk);
      #1;
      if (doneEvents != doneBefore) got = 1;
    end
    checkOutput("doneSeen", got, 1);
    if (!got) expQ.delete();
  endtask

  // Issues one command; ackWait/shWait of 0 hold the response high from the start.
  task automatic applyStimulus(input int op, input int size, input int lsb, input int rs,
                               input int ackWait, input int shWait, input bit busyPoke);
    exp_t e;
    int   n = 32 / widthOf(cur);
    int   w = widthOf(cur);
    bit   mis = (op < 2) && ((size == 1 && lsb == 3) || (size == 2 && lsb != 0));
    int   doneBefore = doneEvents;
    bit   seen;

    e = '{default: 0};
    e.lsb = lsb;
    e.misalign = mis;
    e.enCnt = 0;
    if (mis || op == 3) begin
      e.latency = 1;
    end else if (op == 2) begin
      e.latency = n + shWait + 1 + n + 1;
      e.initCnt = n;
      e.enCnt = -1;
      e.shOpCnt = 2 * n + shWait + 1;
      e.shStateCnt = shWait + 1;
      e.cntDoneCnt = 2;
      e.rsoCnt = rs ? e.shOpCnt : 0;
    end else begin
      e.initCnt = n;
      e.cycCnt = ackWait + 1;
      e.we = (op == 1);
      e.sel = (size == 0) ? (1 << lsb) : ((size == 1) ? (3 << lsb) : 15);
      if (op == 0) begin
        e.latency = n + ackWait + 1 + n + 1;
        e.enCnt = 2 * n;
        e.loadCnt = 1;
        e.bvCnt = n;
        e.cntDoneCnt = 2;
      end else begin
        e.latency = n + ackWait + 2;
        e.enCnt = n;
        e.bvCnt = ((8 << size) >= 32) ? n : ((8 << size) + w - 1) / w;
        e.cntDoneCnt = 1;
      end
    end
    expQ.push_back(e);
    clearMonitor();

    i_op = 2'(op);
    i_size = 2'(size);
    i_addr_lsb = 2'(lsb);
    i_right_shift = rs[0];
    i_wb_ack = (ackWait == 0);
    i_sh_done = (shWait == 0);
    i_start = 1'b1;
    @(posedge i_clk);
    #1;
    i_start = 1'b0;
    if (busyPoke) begin
      i_start = 1'b1;
      i_op = 2'd3;
      @(posedge i_clk);
      #1;
      i_start = 1'b0;
      i_op = 2'(op);
    end
    if (ackWait > 0 && op < 2 && !mis) begin
      seen = 0;
      for (int k = 0; k < 200 && !seen; k++) begin
        @(negedge i_clk);
        seen = obs.wb_cyc;
      end
      checkOutput("cycSeen", seen, 1);
      repeat (ackWait) @(posedge i_clk);
      #1;
      i_wb_ack = 1'b1;
      @(posedge i_clk);
      #1;
      i_wb_ack = 1'b0;
    end
    if (shWait > 0 && op == 2) begin
      seen = 0;
      for (int k = 0; k < 200 && !seen; k++) begin
        @(negedge i_clk);
        seen = obs.shift_op && !obs.init && !obs.en;
      end
      checkOutput("shiftSeen", seen, 1);
      repeat (shWait) @(posedge i_clk);
      #1;
      i_sh_done = 1'b1;
      @(posedge i_clk);
      #1;
      i_sh_done = 1'b0;
    end
    waitDone(doneBefore);
    i_wb_ack = 1'b0;
    i_sh_done = 1'b0;
    repeat (2) @(posedge i_clk);
    #1;
  endtask

  // Reset lands while a load waits for its ack; nothing of the load may complete.
  task automatic resetMidAck();
    int doneBefore = doneEvents;
    bit seen = 0;
    clearMonitor();
    i_op = 2'd0;
    i_size = 2'd2;
    i_addr_lsb = 2'd0;
    i_wb_ack = 1'b0;
    i_start = 1'b1;
    @(posedge i_clk);
    #1;
    i_start = 1'b0;
    for (int k = 0; k < 200 && !seen; k++) begin
      @(negedge i_clk);
      seen = obs.wb_cyc;
    end
    checkOutput("rstCycSeen", seen, 1);
    @(posedge i_clk);
    #1;
    i_rst = 1'b1;
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    @(negedge i_clk);
    checkOutput("rstCycDrop", obs.wb_cyc, 0);
    checkOutput("rstBusy", obs.busy, 0);
    repeat (5) @(posedge i_clk);
    #1;
    checkOutput("rstNoLoad", mLoad, 0);
    checkOutput("rstNoDone", doneEvents, doneBefore);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    clearMonitor();
    @(posedge i_clk);
    #1;
    cur = 0;
    resetDuts();
    applyStimulus(0, 2, 0, 0, 3, 0, 1);
    applyStimulus(3, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 2, 1, 0, 0, 0, 0);

    cur = 2;
    resetDuts();
    applyStimulus(1, 0, 2, 0, 0, 0, 0);
    applyStimulus(1, 1, 3, 0, 0, 0, 0);
    applyStimulus(1, 1, 1, 0, 1, 0, 0);
    applyStimulus(2, 0, 0, 0, 0, 0, 0);

    cur = 1;
    resetDuts();
    applyStimulus(2, 0, 0, 1, 0, 5, 0);
    applyStimulus(0, 1, 2, 0, 0, 0, 0);
    resetMidAck();
    applyStimulus(1, 2, 0, 0, 2, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
